// File: rtl/jtframe_joy_pkg.sv
// Shared types and constants for the ZXDOS serial joystick chain sequencer.
// JOY_MAP gives the destination word and bit for each serial bit k.
package jtframe_joy_pkg;

  localparam int unsigned JOY_NBITS = 24;
  localparam int unsigned JOY_W     = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    REL      = 3'd2,
    SHIFT_LO = 3'd3,
    SHIFT_HI = 3'd4,
    UPDATE   = 3'd5,
    GAP      = 3'd6
  } joy_state_t;

  typedef struct packed {
    logic       sel_j2;
    logic [3:0] pos;
  } joy_map_t;

  // Index k is the k-th bit shifted out of the chain after a parallel load
  localparam joy_map_t JOY_MAP [JOY_NBITS] = '{
    '{1'b0, 4'd8},  '{1'b0, 4'd6},  '{1'b0, 4'd5},  '{1'b0, 4'd4},
    '{1'b0, 4'd0},  '{1'b0, 4'd1},  '{1'b0, 4'd2},  '{1'b0, 4'd3},
    '{1'b1, 4'd8},  '{1'b1, 4'd6},  '{1'b1, 4'd5},  '{1'b1, 4'd4},
    '{1'b1, 4'd0},  '{1'b1, 4'd1},  '{1'b1, 4'd2},  '{1'b1, 4'd3},
    '{1'b1, 4'd10}, '{1'b1, 4'd11}, '{1'b1, 4'd9},  '{1'b1, 4'd7},
    '{1'b0, 4'd10}, '{1'b0, 4'd11}, '{1'b0, 4'd9},  '{1'b0, 4'd7}
  };

endpackage

// File: rtl/jtframe_joy_map.sv
// Combinational decode of one raw chain frame into two active-high joystick words.
// Buttons on the chain are active-low; unmapped bits 15:12 stay zero.
module jtframe_joy_map
  import jtframe_joy_pkg::*;
(
  input  logic [JOY_NBITS-1:0] i_raw,
  output logic [JOY_W-1:0]     o_joy1_c,
  output logic [JOY_W-1:0]     o_joy2_c
);

  always_comb begin
    o_joy1_c = '0;
    o_joy2_c = '0;
    for (int k = 0; k < JOY_NBITS; k++) begin
      if (JOY_MAP[k].sel_j2) o_joy2_c[JOY_MAP[k].pos] = ~i_raw[k];
      else                   o_joy1_c[JOY_MAP[k].pos] = ~i_raw[k];
    end
  end

endmodule

// File: rtl/jtframe_joy_serial_ctrl.sv
// Sequencer for the 24-bit 74HC165-style joystick chain: derives JOY_LOAD/JOY_CLK
// from a clock-enable tick, shifts the frame in, decodes and publishes both joysticks.
module jtframe_joy_serial_ctrl
  import jtframe_joy_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 128,
  parameter int unsigned NBITS     = JOY_NBITS,
  parameter int unsigned GAP_TICKS = 8,
  parameter int unsigned DEBOUNCE  = 0
)(
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             scan_en,
  input  logic             JOY_DATA,
  output logic             JOY_CLK,
  output logic             JOY_LOAD,
  output logic [JOY_W-1:0] joystick1,
  output logic [JOY_W-1:0] joystick2,
  output logic             joy_valid,
  output logic             busy
);

  localparam int unsigned PW = $clog2(CLK_DIV);
  localparam int unsigned KW = $clog2(NBITS);
  localparam int unsigned CW = $clog2(GAP_TICKS + 2);

  joy_state_t           r_state, w_state_nx;
  logic [PW-1:0]        r_presc;
  logic [CW-1:0]        r_cnt, w_cnt_nx;
  logic [KW-1:0]        r_bit, w_bit_nx;
  logic [JOY_NBITS-1:0] r_raw, w_raw_nx, r_prev;
  logic                 r_data_meta, r_data_sync;
  logic                 w_tick, w_accept;
  logic [JOY_W-1:0]     w_joy1, w_joy2;

  assign w_tick   = (r_presc == PW'(CLK_DIV - 1));
  assign w_accept = (DEBOUNCE == 0) || (r_raw == r_prev);

  jtframe_joy_map u_map (
    .i_raw    (r_raw),
    .o_joy1_c (w_joy1),
    .o_joy2_c (w_joy2)
  );

  // Free-running prescaler, never touched by the FSM so the frame period is exact
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) r_presc <= '0;
    else        r_presc <= w_tick ? '0 : r_presc + PW'(1);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bit_nx   = r_bit;
    w_raw_nx   = r_raw;
    unique case (r_state)
      IDLE: if (w_tick && scan_en) begin
        w_state_nx = LOAD;
        w_cnt_nx   = '0;
      end
      LOAD: if (w_tick) begin
        if (r_cnt == CW'(1)) begin
          w_state_nx = REL;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      REL: if (w_tick) begin
        w_state_nx = SHIFT_LO;
        w_bit_nx   = '0;
      end
      SHIFT_LO: if (w_tick) begin
        w_raw_nx[r_bit] = r_data_sync;
        w_state_nx      = SHIFT_HI;
      end
      SHIFT_HI: if (w_tick) begin
        if (r_bit == KW'(NBITS - 1)) begin
          w_state_nx = UPDATE;
        end else begin
          w_bit_nx   = r_bit + KW'(1);
          w_state_nx = SHIFT_LO;
        end
      end
      UPDATE: begin
        w_state_nx = GAP;
        w_cnt_nx   = '0;
      end
      GAP: if (w_tick) begin
        if (r_cnt == CW'(GAP_TICKS - 1)) begin
          w_cnt_nx   = '0;
          w_state_nx = scan_en ? LOAD : IDLE;
        end else begin
          w_cnt_nx = r_cnt + CW'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // Pin outputs follow the next state so they line up with the registered state
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_raw       <= '1;
      r_prev      <= '1;
      JOY_CLK     <= 1'b0;
      JOY_LOAD    <= 1'b1;
      busy        <= 1'b0;
      joystick1   <= '0;
      joystick2   <= '0;
      joy_valid   <= 1'b0;
    end else begin
      r_data_meta <= JOY_DATA;
      r_data_sync <= r_data_meta;
      r_cnt       <= w_cnt_nx;
      r_bit       <= w_bit_nx;
      r_raw       <= w_raw_nx;
      JOY_CLK     <= (w_state_nx == SHIFT_HI);
      JOY_LOAD    <= (w_state_nx != LOAD);
      busy        <= (w_state_nx != IDLE) && (w_state_nx != GAP);
      joy_valid   <= (r_state == UPDATE) && w_accept;
      if (r_state == UPDATE) begin
        r_prev <= r_raw;
        if (w_accept) begin
          joystick1 <= w_joy1;
          joystick2 <= w_joy2;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtframe_joy_serial_ctrl.sv
// Bench for jtframe_joy_serial_ctrl: two instances (DEBOUNCE 0 and 1) share a
// chain pattern; expected frames are queued at load and popped at frame end.
module tb_jtframe_joy_serial_ctrl;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned GAP_TICKS = 8;
  localparam int FRAME = (3 + 2 * 24 + GAP_TICKS) * CLK_DIV;

  typedef struct {
    logic        v0;
    logic [15:0] a0, b0;
    logic        v1;
    logic [15:0] a1, b1;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic        scan_en = 1'b0;
  logic [23:0] pat     = '1;
  logic [23:0] sr0 = '1, sr1 = '1;
  logic        clk0_d = 1'b0, clk1_d = 1'b0;
  logic        clk0, load0, valid0, busy0, clk1, load1, valid1, busy1;
  logic [15:0] j1_0, j2_0, j1_1, j2_1;
  int          n_vec = 0, n_err = 0, cyc = 0, vcnt0 = 0, vcnt1 = 0;

  exp_t        exp_q[$];
  logic [23:0] m_prev1 = '1;
  logic [15:0] m_a1 = '0, m_b1 = '0;
  logic        load0_d = 1'b1;

  always #5 clk_sys = ~clk_sys;

  jtframe_joy_serial_ctrl #(.CLK_DIV(CLK_DIV), .NBITS(24), .GAP_TICKS(GAP_TICKS), .DEBOUNCE(0)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .scan_en(scan_en), .JOY_DATA(sr0[0]),
    .JOY_CLK(clk0), .JOY_LOAD(load0), .joystick1(j1_0), .joystick2(j2_0),
    .joy_valid(valid0), .busy(busy0));

  jtframe_joy_serial_ctrl #(.CLK_DIV(CLK_DIV), .NBITS(24), .GAP_TICKS(GAP_TICKS), .DEBOUNCE(1)) dut_db (
    .clk_sys(clk_sys), .rst_n(rst_n), .scan_en(scan_en), .JOY_DATA(sr1[0]),
    .JOY_CLK(clk1), .JOY_LOAD(load1), .joystick1(j1_1), .joystick2(j2_1),
    .joy_valid(valid1), .busy(busy1));

  // 74HC165 chain models: parallel load while LOAD low, shift on JOY_CLK rise
  always @(posedge clk_sys) begin
    clk0_d <= clk0;
    clk1_d <= clk1;
    if (!load0) sr0 <= pat; else if (clk0 && !clk0_d) sr0 <= {1'b1, sr0[23:1]};
    if (!load1) sr1 <= pat; else if (clk1 && !clk1_d) sr1 <= {1'b1, sr1[23:1]};
    cyc   <= cyc + 1;
    vcnt0 <= vcnt0 + (valid0 ? 1 : 0);
    vcnt1 <= vcnt1 + (valid1 ? 1 : 0);
  end

  function automatic void exp_decode(input logic [23:0] p, output logic [15:0] a, output logic [15:0] b);
    logic [23:0] n;
    n = ~p;
    a = '0;
    b = '0;
    a[8] = n[0];  a[6] = n[1];  a[5] = n[2];  a[4] = n[3];
    a[0] = n[4];  a[1] = n[5];  a[2] = n[6];  a[3] = n[7];
    b[8] = n[8];  b[6] = n[9];  b[5] = n[10]; b[4] = n[11];
    b[0] = n[12]; b[1] = n[13]; b[2] = n[14]; b[3] = n[15];
    b[10] = n[16]; b[11] = n[17]; b[9] = n[18]; b[7] = n[19];
    a[10] = n[20]; a[11] = n[21]; a[9] = n[22]; a[7] = n[23];
  endfunction

  // Scoreboard producer: one entry per frame when the chain latches the pattern
  initial begin
    exp_t        e;
    logic [15:0] a, b;
    forever begin
      @(posedge clk_sys or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        m_prev1 = '1;
        m_a1    = '0;
        m_b1    = '0;
        load0_d = 1'b1;
      end else begin
        if (!load0_d && load0) begin
          exp_decode(pat, a, b);
          e.v0 = 1'b1;
          e.a0 = a;
          e.b0 = b;
          e.v1 = (pat == m_prev1);
          if (e.v1) begin
            m_a1 = a;
            m_b1 = b;
          end
          e.a1 = m_a1;
          e.b1 = m_b1;
          m_prev1 = pat;
          exp_q.push_back(e);
        end
        load0_d = load0;
      end
    end
  end

  task automatic frame_end(input bit fresh, output bit got, output exp_t e, output int dv0, output int dv1);
    int s0, s1, t;
    s0 = vcnt0;
    s1 = vcnt1;
    t  = 0;
    got = 1'b0;
    if (fresh) while (!busy0 && t < 2 * FRAME) begin @(negedge clk_sys); t++; end
    while (busy0 && t < 2 * FRAME) begin @(negedge clk_sys); t++; end
    @(negedge clk_sys);
    dv0 = vcnt0 - s0;
    dv1 = vcnt1 - s1;
    if (t >= 2 * FRAME || exp_q.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL frame_end: cycles=%0d queued=%0d", t, exp_q.size());
    end else begin
      e   = exp_q.pop_front();
      got = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    scan_en = 1'b0;
    pat     = '1;
    repeat (2) @(negedge clk_sys);
    scan_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      n_vec++;
      if ({clk0, load0, valid0, busy0, j1_0, j2_0} !== {4'b0100, 32'h0}) begin
        n_err++; $display("FAIL reset_dut0: got %h expected %h", {clk0, load0, valid0, busy0, j1_0, j2_0}, {4'b0100, 32'h0});
      end
      n_vec++;
      if ({clk1, load1, valid1, busy1, j1_1, j2_1} !== {4'b0100, 32'h0}) begin
        n_err++; $display("FAIL reset_dut1: got %h expected %h", {clk1, load1, valid1, busy1, j1_1, j2_1}, {4'b0100, 32'h0});
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_frame_timing();
    int   t, t0, lowc, rises, dv0, dv1;
    logic pclk;
    bit   got;
    exp_t e;
    t = 0; lowc = 0; rises = 0; pclk = 1'b0;
    while (load0 && t < 2 * FRAME) begin @(negedge clk_sys); t++; end
    t0 = cyc;
    t  = 0;
    while (t < 2 * FRAME) begin
      if (!load0 && rises == 0) lowc++;
      if (clk0 && !pclk) rises++;
      pclk = clk0;
      if (!busy0) break;
      @(negedge clk_sys);
      t++;
    end
    n_vec++;
    if (lowc != 8) begin n_err++; $display("FAIL load_low_cycles: got %0d expected 8", lowc); end
    n_vec++;
    if (rises != 24) begin n_err++; $display("FAIL joy_clk_rises: got %0d expected 24", rises); end
    for (int f = 0; f < 2; f++) begin
      frame_end(1'b0, got, e, dv0, dv1);
      if (got) begin
        n_vec++;
        if ({4'(dv0), j1_0, j2_0} !== {4'(e.v0), e.a0, e.b0} || e.a0 !== 16'h0) begin
          n_err++; $display("FAIL idle_frame_dut0: got %h expected %h", {4'(dv0), j1_0, j2_0}, {4'(e.v0), 32'h0});
        end
        n_vec++;
        if ({4'(dv1), j1_1, j2_1} !== {4'(e.v1), e.a1, e.b1}) begin
          n_err++; $display("FAIL idle_frame_dut1: got %h expected %h", {4'(dv1), j1_1, j2_1}, {4'(e.v1), e.a1, e.b1});
        end
      end
      if (f == 0) begin
        t = 0;
        while (load0 && t < 2 * FRAME) begin @(negedge clk_sys); t++; end
        n_vec++;
        if (cyc - t0 != FRAME) begin n_err++; $display("FAIL frame_period: got %0d expected %0d", cyc - t0, FRAME); end
      end
    end
  endtask

  task automatic test_decode();
    logic [23:0] tp [3];
    logic [15:0] t1 [3];
    logic [15:0] t2 [3];
    int   dv0, dv1;
    bit   got;
    exp_t e;
    tp[0] = ~24'h000010; t1[0] = 16'h0001; t2[0] = 16'h0000;
    tp[1] = ~24'h000200; t1[1] = 16'h0000; t2[1] = 16'h0040;
    tp[2] = ~24'h440000; t1[2] = 16'h0200; t2[2] = 16'h0200;
    for (int i = 0; i < 6; i++) begin
      pat = (i < 3) ? tp[i] : 24'($urandom);
      frame_end(1'b1, got, e, dv0, dv1);
      if (got) begin
        n_vec++;
        if ({4'(dv0), j1_0, j2_0} !== {4'(e.v0), e.a0, e.b0}) begin
          n_err++; $display("FAIL decode_dut0[%0d]: got %h expected %h", i, {4'(dv0), j1_0, j2_0}, {4'(e.v0), e.a0, e.b0});
        end
        n_vec++;
        if ({4'(dv1), j1_1, j2_1} !== {4'(e.v1), e.a1, e.b1}) begin
          n_err++; $display("FAIL decode_dut1[%0d]: got %h expected %h", i, {4'(dv1), j1_1, j2_1}, {4'(e.v1), e.a1, e.b1});
        end
        n_vec++;
        if ({j1_0[15:12], j2_0[15:12]} !== 8'h00) begin
          n_err++; $display("FAIL high_bits[%0d]: got %h expected 00", i, {j1_0[15:12], j2_0[15:12]});
        end
        if (i < 3) begin
          n_vec++;
          if ({j1_0, j2_0} !== {t1[i], t2[i]}) begin
            n_err++; $display("FAIL decode_table[%0d]: got %h expected %h", i, {j1_0, j2_0}, {t1[i], t2[i]});
          end
        end
      end
    end
  endtask

  task automatic test_debounce();
    logic [23:0] seq [6];
    logic [3:0]  ev [6];
    logic [15:0] ej [6];
    int   dv0, dv1;
    bit   got;
    exp_t e;
    seq[0] = '1;          ev[0] = 4'd0; ej[0] = 16'h0000;
    seq[1] = '1;          ev[1] = 4'd1; ej[1] = 16'h0000;
    seq[2] = ~24'h000080; ev[2] = 4'd0; ej[2] = 16'h0000;
    seq[3] = '1;          ev[3] = 4'd0; ej[3] = 16'h0000;
    seq[4] = ~24'h000080; ev[4] = 4'd0; ej[4] = 16'h0000;
    seq[5] = ~24'h000080; ev[5] = 4'd1; ej[5] = 16'h0008;
    for (int i = 0; i < 6; i++) begin
      pat = seq[i];
      frame_end(1'b1, got, e, dv0, dv1);
      if (got) begin
        n_vec++;
        if ({4'(dv0), j1_0, j2_0} !== {4'(e.v0), e.a0, e.b0}) begin
          n_err++; $display("FAIL debounce_dut0[%0d]: got %h expected %h", i, {4'(dv0), j1_0, j2_0}, {4'(e.v0), e.a0, e.b0});
        end
        n_vec++;
        if ({4'(dv1), j1_1, j2_1} !== {4'(e.v1), e.a1, e.b1}) begin
          n_err++; $display("FAIL debounce_model[%0d]: got %h expected %h", i, {4'(dv1), j1_1, j2_1}, {4'(e.v1), e.a1, e.b1});
        end
        if (i > 0) begin
          n_vec++;
          if ({4'(dv1), j1_1, j2_1} !== {ev[i], ej[i], 16'h0}) begin
            n_err++; $display("FAIL debounce_seq[%0d]: got %h expected %h", i, {4'(dv1), j1_1, j2_1}, {ev[i], ej[i], 16'h0});
          end
        end
      end
    end
  endtask

  task automatic test_scan_drop();
    int   t, rises, bad, lat, dv0, dv1;
    logic pclk;
    bit   got;
    exp_t e;
    pat = ~24'h000210;
    t = 0; rises = 0; pclk = 1'b0;
    while (!busy0 && t < 2 * FRAME) begin @(negedge clk_sys); t++; end
    while (rises < 11 && t < 2 * FRAME) begin
      if (clk0 && !pclk) rises++;
      pclk = clk0;
      if (rises < 11) begin @(negedge clk_sys); t++; end
    end
    scan_en = 1'b0;
    frame_end(1'b0, got, e, dv0, dv1);
    if (got) begin
      n_vec++;
      if ({4'(dv0), j1_0, j2_0} !== {4'd1, 16'h0001, 16'h0040}) begin
        n_err++; $display("FAIL scan_drop_frame: got %h expected %h", {4'(dv0), j1_0, j2_0}, {4'd1, 16'h0001, 16'h0040});
      end
    end
    bad = 0;
    for (int i = 0; i < int'((GAP_TICKS + 4) * CLK_DIV); i++) begin
      @(negedge clk_sys);
      if (!load0 || busy0 || clk0 || valid0) bad++;
    end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL scan_drop_activity: got %0d active cycles expected 0", bad); end
    n_vec++;
    if ({clk0, load0, busy0, j1_0, j2_0} !== {3'b010, 16'h0001, 16'h0040}) begin
      n_err++; $display("FAIL scan_drop_idle: got %h expected %h", {clk0, load0, busy0, j1_0, j2_0}, {3'b010, 16'h0001, 16'h0040});
    end
    scan_en = 1'b1;
    lat = 0;
    while (load0 && lat < 4 * int'(CLK_DIV)) begin @(negedge clk_sys); lat++; end
    n_vec++;
    if (lat < 1 || lat > int'(CLK_DIV)) begin
      n_err++; $display("FAIL rearm_latency: got %0d cycles expected 1..%0d", lat, CLK_DIV);
    end
  endtask

  task automatic test_reset_midframe();
    int   t, rises, s0, dv0, dv1;
    logic pclk;
    bit   got;
    exp_t e;
    t = 0; rises = 0; pclk = 1'b0;
    while (rises < 16 && t < 2 * FRAME) begin
      if (clk0 && !pclk) rises++;
      pclk = clk0;
      if (rises < 16) begin @(negedge clk_sys); t++; end
    end
    s0 = vcnt0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({clk0, load0, valid0, busy0, j1_0, j2_0} !== {4'b0100, 32'h0}) begin
      n_err++; $display("FAIL async_reset_dut0: got %h expected %h", {clk0, load0, valid0, busy0, j1_0, j2_0}, {4'b0100, 32'h0});
    end
    n_vec++;
    if ({clk1, load1, valid1, busy1, j1_1, j2_1} !== {4'b0100, 32'h0}) begin
      n_err++; $display("FAIL async_reset_dut1: got %h expected %h", {clk1, load1, valid1, busy1, j1_1, j2_1}, {4'b0100, 32'h0});
    end
    pat = ~24'h440000;
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    frame_end(1'b1, got, e, dv0, dv1);
    if (got) begin
      n_vec++;
      if ({4'(vcnt0 - s0), j1_0, j2_0} !== {4'd1, 16'h0200, 16'h0200}) begin
        n_err++; $display("FAIL post_reset_dut0: got %h expected %h", {4'(vcnt0 - s0), j1_0, j2_0}, {4'd1, 16'h0200, 16'h0200});
      end
      n_vec++;
      if ({4'(dv1), j1_1, j2_1} !== {4'(e.v1), e.a1, e.b1} || dv1 != 0) begin
        n_err++; $display("FAIL post_reset_dut1: got %h expected %h", {4'(dv1), j1_1, j2_1}, {4'd0, 32'h0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_decode();
    test_debounce();
    test_scan_drop();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jtframe_joy_serial_ctrl.md
Name: jtframe_joy_serial_ctrl

Overview:
- Sequencer for the external 24-bit parallel-in/serial-out joystick shift-register chain (74HC165-style) on the ZXDOS board.
- Derives JOY_CLK and JOY_LOAD from a clock enable, so no generated clock is used.
- Samples JOY_DATA, decodes the fixed bit map into two active-high 16-bit joystick words, and publishes them with a one-cycle valid strobe.
- Sits in the board base layer between the board pins and the core's joystick1/joystick2 inputs.

Parameters:
- CLK_DIV, 128: clk_sys cycles per tick. One JOY_CLK phase lasts one tick. Legal range ≥4.
- NBITS, 24: serial bits per frame. Fixed at 24 for the current map; any other value is illegal.
- GAP_TICKS, 8: idle ticks between the end of a shift and the next load. Legal range ≥1.
- DEBOUNCE, 0: 1 means the outputs update only when two consecutive raw frames are identical.

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- scan_en  in  1  enables frame scanning
- JOY_DATA  in  1  serial data from the chain; active-low buttons
- JOY_CLK  out  1  shift clock to the chain
- JOY_LOAD  out  1  parallel load to the chain, active-low
- joystick1  out  16  player 1, active-high
- joystick2  out  16  player 2, active-high
- joy_valid  out  1  one-cycle strobe when the joystick words update
- busy  out  1  high while a frame is in progress (LOAD through UPDATE)

Behaviour:
- Reset values: JOY_CLK=0, JOY_LOAD=1, joystick1=joystick2=0, joy_valid=0, busy=0, state=IDLE, prescaler=0. The stored previous raw frame resets to 24'hFFFFFF.
- Reset asserted mid-frame aborts the frame immediately. The asynchronous clear applies to all of the above.
- JOY_DATA passes through a 2-FF synchroniser; all sampling uses the synchronised value.
- Prescaler:
  - Free-running 0..CLK_DIV-1 counter; tick=1 when it equals CLK_DIV-1.
  - It is never stalled or reloaded by the FSM, so the frame period is exact.
- FSM (transitions occur only on tick, except UPDATE):
  - IDLE: JOY_LOAD=1, JOY_CLK=0. On tick with scan_en=1, go to LOAD.
  - LOAD: JOY_LOAD=0 for exactly 2 ticks, then go to REL.
  - REL: JOY_LOAD=1 for 1 tick, bit index k=0, then go to SHIFT_LO.
  - SHIFT_LO: JOY_CLK=0. On tick, capture synchronised JOY_DATA into raw[k], set JOY_CLK=1, go to SHIFT_HI.
  - SHIFT_HI: on tick, set JOY_CLK=0.
    - If k==NBITS-1, go to UPDATE.
    - Otherwise increment k and go to SHIFT_LO.
  - UPDATE: lasts one clk_sys cycle.
    - Decode raw.
    - Update the outputs and pulse joy_valid, subject to DEBOUNCE.
    - Store raw as the previous frame, then go to GAP.
  - GAP: count GAP_TICKS ticks.
    - At the end, go to LOAD if scan_en=1.
    - Otherwise go to IDLE.
- Frame period while scan_en stays 1: (3 + 2·NBITS + GAP_TICKS)·CLK_DIV clk_sys cycles.
- scan_en deasserted mid-frame: the current frame completes, including UPDATE, then the FSM goes to IDLE. Outputs hold their last value.
- Decode: joystick bit = ~raw[k]. Bits 15:12 of both words are always 0.
- Bit map, raw index k → destination bit:
  - k0..k7 → j1[8], j1[6], j1[5], j1[4], j1[0], j1[1], j1[2], j1[3]
  - k8..k15 → j2[8], j2[6], j2[5], j2[4], j2[0], j2[1], j2[2], j2[3]
  - k16..k19 → j2[10], j2[11], j2[9], j2[7]
  - k20..k23 → j1[10], j1[11], j1[9], j1[7]
- DEBOUNCE=0: every UPDATE writes the outputs and pulses joy_valid.
- DEBOUNCE=1: the outputs are written and joy_valid pulses only if raw equals the previous raw frame. Otherwise the outputs hold and joy_valid stays 0.
- Output register latency: joystick1/joystick2/joy_valid change on the clock edge that ends UPDATE.
- busy=1 from entry to LOAD through UPDATE inclusive, and 0 in GAP and IDLE.

Decomposition:
- Package jtframe_joy_pkg holds:
  - the state encoding (IDLE, LOAD, REL, SHIFT_LO, SHIFT_HI, UPDATE, GAP);
  - the 24-entry bit-map constant, giving a target word and bit per k;
  - JOY_NBITS=24.
- One sub-module is natural: jtframe_joy_map, a combinational raw[23:0] → {joystick1, joystick2} decode driven by the package map.

Test Plan:
- Reset; CLK_DIV=4, GAP_TICKS=8, DEBOUNCE=0, scan_en=1, JOY_DATA=1 constant → JOY_LOAD low for exactly 8 cycles, 24 JOY_CLK rising edges, joy_valid pulses, joystick1=joystick2=16'h0000. The next JOY_LOAD fall comes 236 cycles after the previous one.
- Chain model drives k4 low, all other bits high → joystick1=16'h0001, joystick2=16'h0000. Then k9 low only → joystick2=16'h0040, joystick1=16'h0000.
- k18 and k22 low → joystick1=16'h0200, joystick2=16'h0200; bits 15:12 always 0.
- DEBOUNCE=1; k7 low for a single frame → no output change and no joy_valid for that frame or the next. k7 low for 2 frames → joystick1=16'h0008 with joy_valid on the second frame's UPDATE.
- scan_en dropped during SHIFT_HI at k=10 → the frame completes, joy_valid pulses once, the FSM enters IDLE with JOY_LOAD=1, JOY_CLK=0, busy=0. Re-assert → JOY_LOAD falls on the next tick.
- rst_n pulsed low at k=15 → JOY_CLK=0, JOY_LOAD=1, outputs 0 asynchronously, with no joy_valid. After release, a full clean frame follows.
